// File: rtl/vga_text_engine.sv
// Write-port sequencer for the VGA character buffer: runs CLEAR / SCROLL-UP
// commands and arbitrates the single write port, with host writes always winning.
module vga_text_engine #(
   parameter int unsigned N_COL          = 80,
   parameter int unsigned N_ROW          = 30,
   parameter int unsigned CHARS_PER_WORD = 4,
   parameter int unsigned CHAR_WIDTH     = 7,
   parameter int unsigned BUF_ADDR_WIDTH = 10
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 cmd_valid_i,
   output logic                                 cmd_ready_o,
   input  logic [1:0]                           cmd_op_i,
   input  logic [CHAR_WIDTH-1:0]                fill_char_i,
   output logic                                 busy_o,
   output logic                                 done_o,
   input  logic                                 host_wr_i,
   input  logic [BUF_ADDR_WIDTH-1:0]            host_addr_i,
   input  logic [CHARS_PER_WORD*CHAR_WIDTH-1:0] host_data_i,
   input  logic [CHARS_PER_WORD-1:0]            host_strb_i,
   output logic                                 buf_wr_en_o,
   output logic [BUF_ADDR_WIDTH-1:0]            buf_waddr_o,
   output logic [CHARS_PER_WORD*CHAR_WIDTH-1:0] buf_wdata_o,
   output logic [CHARS_PER_WORD-1:0]            buf_wstrb_o,
   output logic [BUF_ADDR_WIDTH-1:0]            buf_raddr_o,
   input  logic [CHARS_PER_WORD*CHAR_WIDTH-1:0] buf_rdata_i
);

   localparam int unsigned AW  = BUF_ADDR_WIDTH;
   localparam int unsigned DW  = CHARS_PER_WORD * CHAR_WIDTH;
   localparam int unsigned WPR = N_COL / CHARS_PER_WORD;

   localparam logic [AW-1:0] WPR_A      = AW'(WPR);
   localparam logic [AW-1:0] LAST_WORD  = AW'(N_ROW * WPR - 1);
   localparam logic [AW-1:0] LAST_SRC   = AW'((N_ROW - 1) * WPR - 1);
   localparam logic [AW-1:0] FILL_START = AW'((N_ROW - 1) * WPR);

   typedef enum logic [2:0] {
      IDLE, CLR, SCR_RD, SCR_WR, SCR_HOLD, FILL, DONE
   } state_t;

   state_t          state;
   logic [AW-1:0]   ptr;
   logic [DW-1:0]   fill_word;
   logic [DW-1:0]   hold;
   logic            eng_pend;
   logic [DW-1:0]   eng_data;
   logic            grant;

   always_comb begin
      eng_pend = 1'b0;
      eng_data = fill_word;
      case (state)
         CLR, FILL: eng_pend = 1'b1;
         SCR_WR: begin
            eng_pend = 1'b1;
            eng_data = buf_rdata_i;
         end
         SCR_HOLD: begin
            eng_pend = 1'b1;
            eng_data = hold;
         end
         default: ;
      endcase
   end

   assign grant       = eng_pend & ~host_wr_i;
   assign cmd_ready_o = (state == IDLE);
   assign busy_o      = (state != IDLE) && (state != DONE);
   assign done_o      = (state == DONE);
   // Source row is always one row below the destination pointer.
   assign buf_raddr_o = ptr + WPR_A;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         ptr       <= '0;
         fill_word <= '0;
         hold      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid_i) begin
                  fill_word <= {CHARS_PER_WORD{fill_char_i}};
                  ptr       <= '0;
                  case (cmd_op_i)
                     2'b01:   state <= CLR;
                     2'b10:   state <= SCR_RD;
                     default: state <= DONE;
                  endcase
               end
            end
            CLR, FILL: begin
               if (grant) begin
                  if (ptr == LAST_WORD) state <= DONE;
                  else                  ptr   <= ptr + AW'(1);
               end
            end
            SCR_RD: state <= SCR_WR;
            SCR_WR, SCR_HOLD: begin
               // Read data is only valid in SCR_WR, so a stalled copy parks it in hold.
               if (grant) begin
                  if (ptr == LAST_SRC) begin
                     ptr   <= FILL_START;
                     state <= FILL;
                  end else begin
                     ptr   <= ptr + AW'(1);
                     state <= SCR_RD;
                  end
               end else if (state == SCR_WR) begin
                  hold  <= buf_rdata_i;
                  state <= SCR_HOLD;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         buf_wr_en_o <= 1'b0;
         buf_waddr_o <= '0;
         buf_wdata_o <= '0;
         buf_wstrb_o <= '0;
      end else if (host_wr_i) begin
         buf_wr_en_o <= 1'b1;
         buf_waddr_o <= host_addr_i;
         buf_wdata_o <= host_data_i;
         buf_wstrb_o <= host_strb_i;
      end else if (eng_pend) begin
         buf_wr_en_o <= 1'b1;
         buf_waddr_o <= ptr;
         buf_wdata_o <= eng_data;
         buf_wstrb_o <= '1;
      end else begin
         buf_wr_en_o <= 1'b0;
      end
   end

endmodule
